// File: rtl/cla_seq_adder_ctrl_pkg.sv
// Shared definitions for the sequential nibble adder.
//   state_t    : controller FSM states
//   NIB_W      : width of one CLA slice (one nibble)
//   cnt_width(): nibble-counter width for a given nibble count (never 0)
package cla_seq_adder_ctrl_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // $clog2(1) is 0, so a one-nibble build still needs a 1-bit counter.
    function automatic int cnt_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_if.sv
// Operand/result handshake bundle for cla_seq_adder_ctrl.
//   master : the operand source / result sink side
//   slave  : the adder controller side
// Signals: in_valid/in_ready/a/b/cin (operand channel),
//          out_valid/out_ready/sum/cout (result channel), busy (status).
interface cla_seq_adder_ctrl_if
    import cla_seq_adder_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) ();

    localparam int W = NIB_W * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );

endinterface

// File: rtl/cla_seq_adder_ctrl_cla.sv
// bit_4_cla: purely combinational 4-bit carry-lookahead adder slice.
// Ports: a, b (4-bit addends), cin (carry in), s (4-bit sum), cout (carry out).
module bit_4_cla
    import cla_seq_adder_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of g/p and cin, so no carry
    // waits on the carry of the bit below it.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ c;

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// cla_seq_adder_ctrl: adds two 4*NIBBLES-bit operands one nibble per cycle
// on a single bit_4_cla slice, LSB nibble first, with the carry held in a
// register between nibbles.
// Ports:
//   clk  : clock, all state changes on posedge
//   rst  : asynchronous active-high reset
//   bus  : slave side of cla_seq_adder_ctrl_if
//          operands accepted on in_valid & in_ready (IDLE only),
//          result offered on out_valid until out_ready (DONE only),
//          busy high while nibbles are being added (RUN).
module cla_seq_adder_ctrl
    import cla_seq_adder_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    cla_seq_adder_ctrl_if.slave  bus
);

    localparam int               W     = NIB_W * NIBBLES;
    localparam int               CNT_W = cnt_width(NIBBLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NIBBLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             carry_q;
    logic [W-1:0]     sum_q;
    logic             cout_q;

    logic             in_ready;
    logic             out_valid;
    logic             busy;
    logic             accept;
    logic             last_nib;

    logic [NIB_W-1:0] nib_s;
    logic             nib_co;
    logic [W-1:0]     sum_shift;

    // Nibble datapath: always looks at the low nibble of the operand shift
    // registers and at the registered carry.
    bit_4_cla u_cla (
        .a    (a_q[NIB_W-1:0]),
        .b    (b_q[NIB_W-1:0]),
        .cin  (carry_q),
        .s    (nib_s),
        .cout (nib_co)
    );

    assign accept   = bus.in_valid & in_ready;
    assign last_nib = (cnt_q == LAST);

    // New nibble enters at the top; after NIBBLES shifts nibble 0 has
    // walked down to sum[3:0]. Written as a shift of the concatenation so
    // the one-nibble build needs no special case.
    assign sum_shift = W'({nib_s, sum_q} >> NIB_W);

    // ---------------- FSM: state register ----------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: every combinational output gets a default before the case so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept)        state_d = RUN;
            RUN:  if (last_nib)      state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE:    in_ready  = 1'b1;
            RUN:     busy      = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // ---------------- Datapath registers ----------------
    // NOTE: the operand and result registers are ordinary flops, not a
    // memory, and the reset values are observable (sum/cout read 0 after
    // reset), so they are all reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q   <= sum_shift;
                    a_q     <= a_q >> NIB_W;
                    b_q     <= b_q >> NIB_W;
                    carry_q <= nib_co;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_nib) begin
                        cout_q <= nib_co;
                    end
                end
                default: begin
                    // DONE holds everything so sum/cout stay stable under
                    // backpressure.
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed + random self-checking bench for cla_seq_adder_ctrl.
// dut4 is the NIBBLES=4 build, dut1 the NIBBLES=1 build.
module tb_cla_seq_adder_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cla_seq_adder_ctrl_if #(.NIBBLES(4)) bus4 ();
    cla_seq_adder_ctrl_if #(.NIBBLES(1)) bus1 ();

    cla_seq_adder_ctrl #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    cla_seq_adder_ctrl #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands in IDLE and take them on the next edge (E0).
    task automatic accept4(input logic [15:0] a, input logic [15:0] b, input logic cin);
        bus4.a        = a;
        bus4.b        = b;
        bus4.cin      = cin;
        bus4.in_valid = 1'b1;
        check("in_ready_idle", bus4.in_ready, 1'b1);
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        check("busy_after_accept", bus4.busy, 1'b1);
        check("out_valid_after_accept", bus4.out_valid, 1'b0);
    endtask

    // Count edges until out_valid (bounded), then check latency and result.
    task automatic wait_done4(input string tag, input logic [15:0] exp_sum, input logic exp_cout);
        int n;
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            check({tag, "_in_ready_low"}, bus4.in_ready, 1'b0);
            if (bus4.out_valid) break;
        end
        check({tag, "_latency"}, 64'(n), 64'd4);
        check({tag, "_busy_done"}, bus4.busy, 1'b0);
        check({tag, "_sum"}, bus4.sum, exp_sum);
        check({tag, "_cout"}, bus4.cout, exp_cout);
    endtask

    // Hand the result to the sink; controller must be back in IDLE after one edge.
    task automatic finish4(input string tag);
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, bus4.out_valid, 1'b0);
        check({tag, "_in_ready_back"}, bus4.in_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] rexp;
        int          n;

        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b0;

        // ---- reset state ----
        rst = 1'b1;
        #1;
        check("rst_sum", bus4.sum, 16'h0000);
        check("rst_cout", bus4.cout, 1'b0);
        check("rst_out_valid", bus4.out_valid, 1'b0);
        check("rst_busy", bus4.busy, 1'b0);
        check("rst_in_ready", bus4.in_ready, 1'b1);
        check("rst_in_ready_n1", bus1.in_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // ---- NIBBLES=1 build: F + F + 1 = 1F ----
        bus1.a = 4'hF; bus1.b = 4'hF; bus1.cin = 1'b1; bus1.in_valid = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        check("n1_busy", bus1.busy, 1'b1);
        check("n1_out_valid_e0", bus1.out_valid, 1'b0);
        @(posedge clk); #1;
        check("n1_out_valid_e1", bus1.out_valid, 1'b1);
        check("n1_sum", bus1.sum, 4'hF);
        check("n1_cout", bus1.cout, 1'b1);
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
        check("n1_idle", bus1.in_ready, 1'b1);
        check("n1_hold_sum", bus1.sum, 4'hF);

        // ---- carry ripple ----
        accept4(16'hFFFF, 16'h0001, 1'b0);
        wait_done4("ripple", 16'h0000, 1'b1);
        finish4("ripple");
        check("ripple_hold_idle", bus4.sum, 16'h0000);

        // ---- cin path ----
        accept4(16'h1234, 16'h4321, 1'b1);
        wait_done4("cin", 16'h5556, 1'b0);
        finish4("cin");

        // ---- backpressure ----
        accept4(16'h8000, 16'h8000, 1'b0);
        wait_done4("bp", 16'h0000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", bus4.out_valid, 1'b1);
            check("bp_sum", bus4.sum, 16'h0000);
            check("bp_cout", bus4.cout, 1'b1);
            check("bp_in_ready", bus4.in_ready, 1'b0);
        end
        finish4("bp");

        // ---- input isolation: changed a and held in_valid during RUN/DONE ----
        accept4(16'h00FF, 16'h0001, 1'b0);
        bus4.a        = 16'hFFFF;
        bus4.in_valid = 1'b1;
        wait_done4("iso", 16'h0100, 1'b0);
        finish4("iso");
        // The held request is taken only now, in IDLE.
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        check("iso2_busy", bus4.busy, 1'b1);
        wait_done4("iso2", 16'h0000, 1'b1);
        finish4("iso2");

        // ---- reset in the 2nd RUN cycle ----
        accept4(16'h7777, 16'h9999, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", bus4.out_valid, 1'b0);
        check("mid_rst_sum", bus4.sum, 16'h0000);
        check("mid_rst_cout", bus4.cout, 1'b0);
        check("mid_rst_busy", bus4.busy, 1'b0);
        check("mid_rst_in_ready", bus4.in_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        accept4(16'hABCD, 16'h1234, 1'b0);
        wait_done4("post_rst", 16'hBE01, 1'b0);
        finish4("post_rst");

        // ---- random back-to-back ----
        for (int k = 0; k < 1000; k++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom);
            rexp = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
            bus4.a = ra; bus4.b = rb; bus4.cin = rc; bus4.in_valid = 1'b1;
            bus4.out_ready = 1'b1;
            n = 0;
            while (!bus4.in_ready && n < 20) begin
                @(posedge clk); #1; n++;
            end
            @(posedge clk); #1;
            bus4.in_valid = 1'b0;
            n = 0;
            while (!bus4.out_valid && n < 20) begin
                @(posedge clk); #1; n++;
            end
            check("rand_result", {bus4.cout, bus4.sum}, rexp);
        end
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
        check("rand_end_idle", bus4.in_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
